// File: rtl/cpu_trap_unit.sv
// Machine-mode trap responder.
//
// Owns the M-mode trap CSRs and, when an instruction commits in RUN, decides
// between interrupt entry, exception entry, mret or a plain CSR write. A trap
// or mret parks the unit in REDIRECT, where it presents the new PC to fetch
// and stalls the core until fetch accepts it.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   instr_valid       an instruction commits; qualifies pc..csr_wdata
//   pc, instr         PC and raw encoding of the committing instruction
//   exception         synchronous exception, cause in exception_cause
//   mret              committing instruction is mret
//   csr_write         committing instruction writes csr_addr with csr_wdata
//   csr_addr          CSR address for both read and write
//   csr_rdata         combinational read of csr_addr
//   irq_ext, irq_timer level interrupt lines, sampled only when deciding
//   redirect_valid/pc/ready  redirect handshake towards fetch
//   stall             high exactly while a redirect is pending
//   trap_taken        one-cycle pulse after a trap (not mret) is entered
module cpu_trap_unit #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        exception,
  input  logic [1:0]  exception_cause,
  input  logic        mret,
  input  logic        csr_write,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  input  logic        irq_ext,
  input  logic        irq_timer,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        stall,
  output logic        trap_taken
);

  localparam logic [11:0] CsrMstatus  = 12'h300;
  localparam logic [11:0] CsrMie      = 12'h304;
  localparam logic [11:0] CsrMtvec    = 12'h305;
  localparam logic [11:0] CsrMscratch = 12'h340;
  localparam logic [11:0] CsrMepc     = 12'h341;
  localparam logic [11:0] CsrMcause   = 12'h342;
  localparam logic [11:0] CsrMtval    = 12'h343;
  localparam logic [11:0] CsrMip      = 12'h344;

  typedef enum logic [0:0] {StRun, StRedirect} state_e;

  state_e      state_q;
  logic        mstatus_mie_q;
  logic        mstatus_mpie_q;
  logic        mie_meie_q;
  logic        mie_mtie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;
  logic [31:0] mtval_q;
  logic [31:0] redirect_pc_q;
  logic        trap_taken_q;

  logic        irq_ext_en;
  logic        irq_timer_en;
  logic        irq_pending;
  logic        decide;
  logic        take_irq;
  logic        take_exc;
  logic        take_trap;
  logic        take_mret;
  logic        do_write;
  logic [4:0]  irq_code;
  logic [31:0] trap_base;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic [31:0] trap_target;

  // Decision priority: interrupt, exception, mret, plain CSR write.
  always_comb begin
    irq_ext_en   = mie_meie_q & irq_ext;
    irq_timer_en = mie_mtie_q & irq_timer;
    irq_pending  = mstatus_mie_q & (irq_ext_en | irq_timer_en);
    decide       = (state_q == StRun) & instr_valid;
    take_irq     = decide & irq_pending;
    take_exc     = decide & ~irq_pending & exception;
    take_trap    = take_irq | take_exc;
    take_mret    = decide & ~irq_pending & ~exception & mret;
    do_write     = decide & ~irq_pending & ~exception & ~mret & csr_write;
  end

  always_comb begin
    irq_code    = irq_ext_en ? 5'd11 : 5'd7;
    trap_base   = {mtvec_q[31:2], 2'b00};
    trap_cause  = 32'd0;
    trap_tval   = 32'd0;
    trap_target = trap_base;
    if (irq_pending) begin
      trap_cause = {1'b1, 26'd0, irq_code};
      // Vectored mode offsets only interrupts, by 4 x cause code.
      if (mtvec_q[0]) begin
        trap_target = trap_base + {25'd0, irq_code, 2'b00};
      end
    end else begin
      case (exception_cause)
        2'b01: begin
          trap_cause = 32'd3;
          trap_tval  = pc;
        end
        2'b10: begin
          trap_cause = 32'd11;
          trap_tval  = 32'd0;
        end
        default: begin
          // Reserved cause 2'b11 is reported as illegal instruction.
          trap_cause = 32'd2;
          trap_tval  = instr;
        end
      endcase
    end
  end

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      CsrMstatus:  csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      CsrMie:      csr_rdata = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
      CsrMtvec:    csr_rdata = mtvec_q;
      CsrMscratch: csr_rdata = mscratch_q;
      CsrMepc:     csr_rdata = mepc_q;
      CsrMcause:   csr_rdata = mcause_q;
      CsrMtval:    csr_rdata = mtval_q;
      CsrMip:      csr_rdata = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};
      default:     csr_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mie_mtie_q     <= 1'b0;
      mtvec_q        <= {RESET_MTVEC[31:2], 1'b0, RESET_MTVEC[0]};
      mscratch_q     <= 32'd0;
      mepc_q         <= 32'd0;
      mcause_q       <= 32'd0;
      mtval_q        <= 32'd0;
      redirect_pc_q  <= 32'd0;
      trap_taken_q   <= 1'b0;
    end else begin
      trap_taken_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (take_trap) begin
            mepc_q         <= {pc[31:2], 2'b00};
            mcause_q       <= trap_cause;
            mtval_q        <= trap_tval;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            redirect_pc_q  <= trap_target;
            trap_taken_q   <= 1'b1;
            state_q        <= StRedirect;
          end else if (take_mret) begin
            mstatus_mie_q  <= mstatus_mpie_q;
            mstatus_mpie_q <= 1'b1;
            redirect_pc_q  <= mepc_q;
            state_q        <= StRedirect;
          end else if (do_write) begin
            case (csr_addr)
              CsrMstatus: begin
                mstatus_mie_q  <= csr_wdata[3];
                mstatus_mpie_q <= csr_wdata[7];
              end
              CsrMie: begin
                mie_meie_q <= csr_wdata[11];
                mie_mtie_q <= csr_wdata[7];
              end
              CsrMtvec:    mtvec_q    <= {csr_wdata[31:2], 1'b0, csr_wdata[0]};
              CsrMscratch: mscratch_q <= csr_wdata;
              CsrMepc:     mepc_q     <= {csr_wdata[31:2], 2'b00};
              CsrMcause:   mcause_q   <= csr_wdata;
              CsrMtval:    mtval_q    <= csr_wdata;
              default:     ;
            endcase
          end
        end
        StRedirect: begin
          if (redirect_ready) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign redirect_valid = (state_q == StRedirect);
  assign stall          = (state_q == StRedirect);
  assign redirect_pc    = redirect_pc_q;
  assign trap_taken     = trap_taken_q;

endmodule

// File: tb/tb_cpu_trap_unit.sv
// Self-checking bench for cpu_trap_unit: CSR write/readback table, directed
// trap/return sequences and a randomized run against a behavioural model.
module tb_cpu_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        exception;
  logic [1:0]  exception_cause;
  logic        mret;
  logic        csr_write;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        irq_ext;
  logic        irq_timer;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        stall;
  logic        trap_taken;

  int checks   = 0;
  int failures = 0;

  cpu_trap_unit #(.RESET_MTVEC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst            (rst),
    .instr_valid    (instr_valid),
    .pc             (pc),
    .instr          (instr),
    .exception      (exception),
    .exception_cause(exception_cause),
    .mret           (mret),
    .csr_write      (csr_write),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .irq_ext        (irq_ext),
    .irq_timer      (irq_timer),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .stall          (stall),
    .trap_taken     (trap_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%08h required=%08h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    csr_addr = a;
    #1;
    check(name, csr_rdata, exp);
  endtask

  task automatic clear_inputs();
    instr_valid = 0; pc = 0; instr = 0; exception = 0; exception_cause = 0;
    mret = 0; csr_write = 0; csr_addr = 0; csr_wdata = 0;
    irq_ext = 0; irq_timer = 0; redirect_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  // One commit cycle; returns 1 time unit after the edge that ends it.
  task automatic commit(input logic [31:0] p, input logic [31:0] ins, input logic exc,
                        input logic [1:0] cause, input logic mr, input logic cw,
                        input logic [11:0] a, input logic [31:0] wd);
    instr_valid = 1; pc = p; instr = ins; exception = exc; exception_cause = cause;
    mret = mr; csr_write = cw; csr_addr = a; csr_wdata = wd;
    @(posedge clk); #1;
    instr_valid = 0; exception = 0; mret = 0; csr_write = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] wd);
    commit(32'h0, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, a, wd);
  endtask

  task automatic accept_redirect();
    redirect_ready = 1;
    @(posedge clk); #1;
    redirect_ready = 0;
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [31:0] m_rpc;
  bit          m_redir, m_tt;

  task automatic model_reset();
    m_mstatus = 0; m_mie = 0; m_mtvec = 32'h100; m_mscratch = 0;
    m_mepc = 0; m_mcause = 0; m_mtval = 0; m_rpc = 0; m_redir = 0; m_tt = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_enter(input logic [31:0] cause, input logic [31:0] tval,
                             input logic [31:0] tgt);
    m_mepc    = pc & ~32'h3;
    m_mcause  = cause;
    m_mtval   = tval;
    m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
    m_rpc     = tgt;
    m_redir   = 1;
    m_tt      = 1;
  endtask

  task automatic model_step();
    bit ext, tmr;
    int unsigned code;
    logic [31:0] base;
    if (rst) begin
      model_reset();
      return;
    end
    m_tt = 0;
    if (m_redir) begin
      if (redirect_ready) m_redir = 0;
      return;
    end
    if (!instr_valid) return;
    ext  = m_mstatus[3] && m_mie[11] && irq_ext;
    tmr  = m_mstatus[3] && m_mie[7] && irq_timer;
    base = m_mtvec & ~32'h3;
    if (ext || tmr) begin
      code = ext ? 11 : 7;
      model_enter(32'h8000_0000 | code, 0, base + (m_mtvec[0] ? 4 * code : 0));
    end else if (exception) begin
      case (exception_cause)
        2'b01:   model_enter(3, pc, base);
        2'b10:   model_enter(11, 0, base);
        default: model_enter(2, instr, base);
      endcase
    end else if (mret) begin
      m_rpc     = m_mepc;
      m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
      m_redir   = 1;
    end else if (csr_write) begin
      case (csr_addr)
        12'h300: m_mstatus  = csr_wdata & 32'h88;
        12'h304: m_mie      = csr_wdata & 32'h880;
        12'h305: m_mtvec    = csr_wdata & ~32'h2;
        12'h340: m_mscratch = csr_wdata;
        12'h341: m_mepc     = csr_wdata & ~32'h3;
        12'h342: m_mcause   = csr_wdata;
        12'h343: m_mtval    = csr_wdata;
        default: ;
      endcase
    end
  endtask

  // ---------------- CSR write/readback table ----------------
  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[10];
  logic [11:0] rnd_addrs[10];

  initial begin
    vecs[0] = '{12'h341, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    vecs[1] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
    vecs[3] = '{12'h304, 32'hFFFF_FFFF, 32'h0000_0880};
    vecs[4] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{12'h340, 32'h1234_5678, 32'h1234_5678};
    vecs[6] = '{12'h342, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[7] = '{12'h343, 32'hCAFE_F00D, 32'hCAFE_F00D};
    vecs[8] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[9] = '{12'h300, 32'h0000_0000, 32'h0000_0000};
    rnd_addrs = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                  12'h342, 12'h343, 12'h344, 12'h7C0, 12'h001};

    rst = 1;
    clear_inputs();
    do_reset();
    check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_trap_taken", {31'd0, trap_taken}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    read_chk("reset_mtvec", 12'h305, 32'h100);

    for (int i = 0; i < 10; i++) begin
      csr_wr(vecs[i].addr, vecs[i].wdata);
      check($sformatf("tbl%0d_no_redirect", i), {31'd0, redirect_valid}, 32'd0);
      read_chk($sformatf("tbl%0d_readback_%03h", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
    end

    // Ecall, direct mode.
    do_reset();
    csr_wr(12'h300, 32'h8);
    commit(32'h200, 32'h0000_0073, 1'b1, 2'b10, 1'b0, 1'b0, 12'h0, 32'h0);
    check("ecall_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("ecall_stall", {31'd0, stall}, 32'd1);
    check("ecall_redirect_pc", redirect_pc, 32'h100);
    check("ecall_trap_taken", {31'd0, trap_taken}, 32'd1);
    read_chk("ecall_mepc", 12'h341, 32'h200);
    read_chk("ecall_mcause", 12'h342, 32'd11);
    read_chk("ecall_mstatus", 12'h300, 32'h80);
    accept_redirect();
    check("ecall_back_run", {31'd0, redirect_valid}, 32'd0);
    check("ecall_trap_pulse_end", {31'd0, trap_taken}, 32'd0);

    // Return.
    commit(32'h0, 32'h3020_0073, 1'b0, 2'b00, 1'b1, 1'b0, 12'h0, 32'h0);
    check("mret_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    check("mret_redirect_pc", redirect_pc, 32'h200);
    check("mret_trap_taken", {31'd0, trap_taken}, 32'd0);
    read_chk("mret_mstatus", 12'h300, 32'h88);
    accept_redirect();

    // Illegal instruction with ready held low; commits in REDIRECT are ignored.
    commit(32'h44, 32'hFFFF_FFFF, 1'b1, 2'b00, 1'b0, 1'b0, 12'h0, 32'h0);
    read_chk("illegal_mcause", 12'h342, 32'd2);
    read_chk("illegal_mtval", 12'h343, 32'hFFFF_FFFF);
    for (int k = 0; k < 4; k++) begin
      instr_valid = 1; csr_write = 1; csr_addr = 12'h340; csr_wdata = 32'hBAD;
      redirect_ready = (k == 3);
      #1;
      check($sformatf("held%0d_stall", k), {31'd0, stall}, 32'd1);
      check($sformatf("held%0d_redirect_valid", k), {31'd0, redirect_valid}, 32'd1);
      check($sformatf("held%0d_redirect_pc", k), redirect_pc, 32'h100);
      @(posedge clk); #1;
    end
    instr_valid = 0; csr_write = 0; redirect_ready = 0;
    check("held_back_run", {31'd0, stall}, 32'd0);
    read_chk("held_mscratch_untouched", 12'h340, 32'h0);

    // Vectored timer interrupt suppresses the CSR write.
    csr_wr(12'h305, 32'h101);
    csr_wr(12'h304, 32'h80);
    csr_wr(12'h300, 32'h8);
    irq_timer = 1;
    commit(32'h300, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h340, 32'h55);
    irq_timer = 0;
    check("timer_redirect_pc", redirect_pc, 32'h11C);
    check("timer_trap_taken", {31'd0, trap_taken}, 32'd1);
    read_chk("timer_mcause", 12'h342, 32'h8000_0007);
    read_chk("timer_mepc", 12'h341, 32'h300);
    read_chk("timer_mscratch", 12'h340, 32'h0);
    read_chk("timer_mtval", 12'h343, 32'h0);
    accept_redirect();

    // External beats timer; then with MIE clear nothing traps.
    csr_wr(12'h304, 32'h880);
    csr_wr(12'h300, 32'h8);
    irq_ext = 1; irq_timer = 1;
    commit(32'h400, 32'h0, 1'b0, 2'b00, 1'b0, 1'b0, 12'h0, 32'h0);
    check("prio_redirect_pc", redirect_pc, 32'h12C);
    read_chk("prio_mcause", 12'h342, 32'h8000_000B);
    read_chk("prio_mip", 12'h344, 32'h880);
    accept_redirect();
    commit(32'h404, 32'h0, 1'b0, 2'b00, 1'b0, 1'b1, 12'h340, 32'h77);
    check("masked_no_redirect", {31'd0, redirect_valid}, 32'd0);
    check("masked_no_trap", {31'd0, trap_taken}, 32'd0);
    read_chk("masked_mscratch", 12'h340, 32'h77);
    irq_ext = 0; irq_timer = 0;

    // Reset while in REDIRECT.
    commit(32'h500, 32'h0, 1'b1, 2'b10, 1'b0, 1'b0, 12'h0, 32'h0);
    check("rstmid_in_redirect", {31'd0, redirect_valid}, 32'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rstmid_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    check("rstmid_stall", {31'd0, stall}, 32'd0);
    check("rstmid_trap_taken", {31'd0, trap_taken}, 32'd0);
    read_chk("rstmid_mstatus", 12'h300, 32'h0);
    read_chk("rstmid_mie", 12'h304, 32'h0);
    read_chk("rstmid_mtvec", 12'h305, 32'h100);
    read_chk("rstmid_mscratch", 12'h340, 32'h0);
    read_chk("rstmid_mepc", 12'h341, 32'h0);
    read_chk("rstmid_mcause", 12'h342, 32'h0);
    read_chk("rstmid_mtval", 12'h343, 32'h0);

    // Randomized run against the model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      rst             = ($urandom_range(63) == 0);
      instr_valid     = ($urandom_range(3) != 0);
      pc              = $urandom;
      instr           = $urandom;
      exception       = ($urandom_range(7) == 0);
      exception_cause = 2'($urandom_range(3));
      mret            = ($urandom_range(7) == 0);
      csr_write       = ($urandom_range(1) == 0);
      csr_addr        = rnd_addrs[$urandom_range(9)];
      csr_wdata       = $urandom;
      irq_ext         = ($urandom_range(5) == 0);
      irq_timer       = ($urandom_range(5) == 0);
      redirect_ready  = ($urandom_range(1) == 0);
      #1;
      check($sformatf("rnd%0d_rdata_%03h", c, csr_addr), csr_rdata, model_read(csr_addr));
      check($sformatf("rnd%0d_redirect_valid", c), {31'd0, redirect_valid}, {31'd0, m_redir});
      check($sformatf("rnd%0d_stall", c), {31'd0, stall}, {31'd0, m_redir});
      check($sformatf("rnd%0d_trap_taken", c), {31'd0, trap_taken}, {31'd0, m_tt});
      if (m_redir) check($sformatf("rnd%0d_redirect_pc", c), redirect_pc, m_rpc);
      model_step();
      @(posedge clk); #1;
    end
    rst = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_trap_unit.md
# cpu_trap_unit

Machine-mode trap responder for the CPU core. It consumes the `exception`, `exception_cause` and `csr_write` outputs of the instruction decoder, plus the `mret` request and the external and timer interrupt lines. It owns the M-mode trap CSRs and takes the trap or `mret` decision when an instruction commits. It then issues a PC redirect to the fetch unit over a valid/ready handshake, and stalls the core until the fetch unit accepts it.

## Interface
- `RESET_MTVEC`, default 32'h0000_0100: reset value of `mtvec`.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instr_valid` in 1: an instruction commits this cycle; all per-instruction inputs are qualified by it.
- `pc` in 32: PC of the committing instruction.
- `instr` in 32: raw encoding of the committing instruction.
- `exception` in 1: the committing instruction raises a synchronous exception.
- `exception_cause` in 2: cause code; 2'b00 illegal instruction, 2'b01 breakpoint, 2'b10 ecall; 2'b11 is reserved and treated as illegal.
- `mret` in 1: the committing instruction is `mret`.
- `csr_write` in 1: the committing instruction writes a CSR.
- `csr_addr` in 12: CSR address, used for both read and write.
- `csr_wdata` in 32: CSR write data, already computed by the ALU.
- `csr_rdata` out 32: combinational read of `csr_addr`.
- `irq_ext` in 1: level machine external interrupt.
- `irq_timer` in 1: level machine timer interrupt.
- `redirect_valid` out 1: a redirect is pending.
- `redirect_pc` out 32: redirect target; stable while `redirect_valid` is high.
- `redirect_ready` in 1: the fetch unit accepts the redirect.
- `stall` out 1: the core must not commit instructions.
- `trap_taken` out 1: one-cycle pulse when a trap (not `mret`) is entered.

## Operation
- **Implemented CSRs**
  - `mstatus` 0x300: bits MIE[3] and MPIE[7] are implemented; all other bits read 0.
  - `mie` 0x304: bits MEIE[11] and MTIE[7] are implemented.
  - `mtvec` 0x305: bit[1] is forced to 0; bit[0] is the mode (0 direct, 1 vectored).
  - `mscratch` 0x340: full 32-bit register.
  - `mepc` 0x341: bits[1:0] are forced to 0.
  - `mcause` 0x342 and `mtval` 0x343: full 32-bit registers.
  - `mip` 0x344: read-only; MEIP[11] = `irq_ext`, MTIP[7] = `irq_timer`.
  - Unimplemented addresses read 0; writes to them are ignored.
- **Reset values:** all CSRs 0 except `mtvec` = `RESET_MTVEC`. State RUN. `redirect_valid` 0, `redirect_pc` 0, `trap_taken` 0, `stall` 0.
- **Pending interrupt:** exists when MIE is set and (MEIE & `irq_ext`) or (MTIE & `irq_timer`). External takes priority over timer.
- **Decision:** made in state RUN on a cycle with `instr_valid` high. Priority, highest first:
  1. **Interrupt.** The instruction is not executed and its CSR write is suppressed. `mepc` ← `pc`; `mcause` ← 32'h8000_000B (external) or 32'h8000_0007 (timer); `mtval` ← 0.
  2. **Exception.** The CSR write is suppressed. `mepc` ← `pc`. `mcause` ← 2 (illegal or reserved), 3 (breakpoint) or 11 (ecall). `mtval` ← `instr` for illegal, `pc` for breakpoint, 0 for ecall.
  3. **`mret`.** MIE ← MPIE, MPIE ← 1; redirect target = `mepc`.
  4. **Otherwise:** if `csr_write` is high, write `csr_wdata` to `csr_addr`.
- **Trap entry (cases 1 and 2):**
  - MPIE ← MIE, MIE ← 0.
  - Target = `mtvec` & ~3.
  - In vectored mode, an interrupt target adds 4 × cause code; exceptions always use the base.
- **State machine:** RUN and REDIRECT.
  - RUN → REDIRECT on any trap or `mret` decision.
  - REDIRECT → RUN on a cycle with `redirect_ready` high.
  - In REDIRECT, `instr_valid` is ignored, no CSR writes occur and no new decision is made.
- **`mret` with an interrupt pending:** MIE has just been restored, so the interrupt is evaluated on the first committing instruction after the return to RUN.

## Timing
- The decision is made in cycle N. CSR updates take effect at the rising edge that ends cycle N.
- From cycle N+1: `redirect_valid` = 1, `stall` = 1 and `redirect_pc` holds the registered target.
- `trap_taken` is registered and is high in cycle N+1 only.
- If `redirect_ready` is high in cycle N+1, the unit is back in RUN at cycle N+2. Minimum redirect occupancy is 1 cycle. `redirect_ready` high while in RUN is ignored.
- `stall` is a function of the state only (high exactly in REDIRECT).
- `csr_rdata` is combinational. In cycle N it returns the value before any update made at the end of N.
- Interrupt lines are sampled only in decision cycles. A pulse that falls outside a decision cycle is lost; there is no latching.
- `rst` in REDIRECT forces RUN next cycle and drops `redirect_valid` and `trap_taken`. The pending redirect is discarded.

## Test plan
- **Ecall, direct mode.** Reset; MIE=1; ecall commits at `pc`=0x200. Require next cycle: `redirect_pc`=0x100, `trap_taken`=1, `mepc`=0x200, `mcause`=11, MIE=0, MPIE=1.
- **Illegal instruction with held ready.** `instr`=0xFFFF_FFFF, `exception_cause`=00 at `pc`=0x44, `redirect_ready` held low for 3 cycles. Require `mcause`=2 and `mtval`=0xFFFF_FFFF. Require `stall` and `redirect_valid` high, with `redirect_pc` stable, for 4 cycles; RUN the cycle after ready.
- **Vectored timer interrupt.** `mtvec`=0x101, MIE=1, MTIE=1, `irq_timer`=1; an instruction commits at `pc`=0x300 with `csr_write` writing `mscratch`=0x55. Require `redirect_pc`=0x11C, `mcause`=0x8000_0007, `mepc`=0x300, `mscratch` unchanged.
- **Interrupt priority and masking.** `irq_ext` and `irq_timer` both high with both enables set: require `mcause`=0x8000_000B. With MIE=0: no trap, and the CSR write proceeds.
- **Return.** After the ecall test, `mret` commits. Require `redirect_pc`=0x200, MIE=1, MPIE=1, `trap_taken`=0.
- **Reset mid-redirect and masked writes.** Assert `rst` in REDIRECT: next cycle `redirect_valid`=0, `stall`=0, all CSRs at reset values. Write 0xFFFF_FFFF to `mepc`: it reads 0xFFFF_FFFC. Write to 0x7C0: it reads 0.
